// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer predictor.
// Entry layout is {tag, target, ctr}; ctr is a 2-bit saturating direction counter.
package btb_pkg;

    localparam int unsigned BTB_ADDR_W  = 32;
    localparam int unsigned BTB_IDX_W   = 7;
    localparam int unsigned BTB_TAG_W   = 23;
    localparam int unsigned BTB_ENTRY_W = 57;

    typedef struct packed {
        logic [BTB_TAG_W-1:0]  tag;
        logic [BTB_ADDR_W-1:0] target;
        logic [1:0]            ctr;
    } btb_entry_t;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        unique case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch lookup, execute update, flush and statistics signals of the BTB predictor.
// master = fetch/execute side, slave = predictor.
interface btb_predictor_if;
    import btb_pkg::*;

    logic                  lk_valid;
    logic                  lk_ready;
    logic [BTB_ADDR_W-1:0] lk_pc;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [BTB_ADDR_W-1:0] pred_target;
    logic                  upd_valid;
    logic                  upd_ready;
    logic [BTB_ADDR_W-1:0] upd_pc;
    logic                  upd_taken;
    logic [BTB_ADDR_W-1:0] upd_target;
    logic                  flush;
    logic [31:0]           stat_lookups;
    logic [31:0]           stat_hits;

    modport master (
        output lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        input  lk_ready, pred_valid, pred_taken, pred_target, upd_ready,
               stat_lookups, stat_hits
    );

    modport slave (
        input  lk_valid, lk_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        output lk_ready, pred_valid, pred_taken, pred_target, upd_ready,
               stat_lookups, stat_hits
    );

endinterface

// File: rtl/btb_array.sv
// Single-port BTB storage: combinational read, synchronous write, contents not reset.
module btb_array #(
    parameter int unsigned Width = 57,
    parameter int unsigned Depth = 128,
    parameter int unsigned IdxW  = 7
) (
    input  logic             clk_i,
    input  logic [IdxW-1:0]  idx_i,
    input  logic             we_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/btb_predictor.sv
// Fetch-side BTB predictor: registered lookups, one-entry update buffer draining by RMW.
// Optional hit/lookup counters under `BTB_PREDICTOR_STATS_EN (ports tied to 0 otherwise).
module btb_predictor
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 128,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    btb_predictor_if.slave  bus
);

    logic                   pend_q, pend_d;
    logic [BTB_IDX_W-1:0]   pend_idx_q, pend_idx_d;
    logic [BTB_TAG_W-1:0]   pend_tag_q, pend_tag_d;
    logic                   pend_taken_q, pend_taken_d;
    logic [ADDR_W-1:0]      pend_target_q, pend_target_d;
    logic [ENTRIES-1:0]     valid_q, valid_d;
    logic                   pred_valid_q, pred_valid_d;
    logic                   pred_taken_q, pred_taken_d;
    logic [BTB_ADDR_W-1:0]  pred_target_q, pred_target_d;

    logic                   drain, upd_rdy, capture, lk_rdy, lk_fire, entry_hit, arr_we;
    logic [BTB_IDX_W-1:0]   arr_idx;
    logic [BTB_TAG_W-1:0]   cmp_tag;
    logic [BTB_ENTRY_W-1:0] arr_rdata;
    btb_entry_t             rd_entry, wr_entry;
    logic                   unused_pc_lsbs;

    assign unused_pc_lsbs = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

    btb_array #(
        .Width (BTB_ENTRY_W),
        .Depth (ENTRIES),
        .IdxW  (BTB_IDX_W)
    ) u_array (
        .clk_i   (clk),
        .idx_i   (arr_idx),
        .we_i    (arr_we),
        .wdata_i (wr_entry),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        drain     = pend_q & ~bus.flush;
        upd_rdy   = ~pend_q | drain;
        // Handshake still completes under flush; the payload is simply discarded.
        capture   = bus.upd_valid & upd_rdy & ~bus.flush;
        lk_rdy    = ~pend_q & ~bus.flush;
        lk_fire   = bus.lk_valid & lk_rdy;
        arr_idx   = pend_q ? pend_idx_q : bus.lk_pc[8:2];
        cmp_tag   = pend_q ? pend_tag_q : bus.lk_pc[31:9];
        rd_entry  = btb_entry_t'(arr_rdata);
        entry_hit = valid_q[arr_idx] & (rd_entry.tag == cmp_tag);

        wr_entry.tag    = pend_tag_q;
        wr_entry.target = pend_taken_q ? pend_target_q : rd_entry.target;
        wr_entry.ctr    = entry_hit ? ctr_next(rd_entry.ctr, pend_taken_q) : WT;
        arr_we          = drain & (entry_hit | pend_taken_q);

        valid_d = valid_q;
        if (bus.flush) valid_d = '0;
        else if (drain & ~entry_hit & pend_taken_q) valid_d[pend_idx_q] = 1'b1;

        pend_d        = pend_q;
        pend_idx_d    = pend_idx_q;
        pend_tag_d    = pend_tag_q;
        pend_taken_d  = pend_taken_q;
        pend_target_d = pend_target_q;
        if (bus.flush) begin
            pend_d = 1'b0;
        end else if (capture) begin
            pend_d        = 1'b1;
            pend_idx_d    = bus.upd_pc[8:2];
            pend_tag_d    = bus.upd_pc[31:9];
            pend_taken_d  = bus.upd_taken;
            pend_target_d = bus.upd_target;
        end else if (drain) begin
            pend_d = 1'b0;
        end

        pred_valid_d  = lk_fire;
        pred_taken_d  = lk_fire ? (entry_hit & rd_entry.ctr[1]) : pred_taken_q;
        pred_target_d = lk_fire ? (entry_hit ? rd_entry.target : '0) : pred_target_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q        <= 1'b0;
            pend_idx_q    <= '0;
            pend_tag_q    <= '0;
            pend_taken_q  <= 1'b0;
            pend_target_q <= '0;
            valid_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pend_q        <= pend_d;
            pend_idx_q    <= pend_idx_d;
            pend_tag_q    <= pend_tag_d;
            pend_taken_q  <= pend_taken_d;
            pend_target_q <= pend_target_d;
            valid_q       <= valid_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign bus.lk_ready    = lk_rdy;
    assign bus.upd_ready   = upd_rdy;
    assign bus.pred_valid  = pred_valid_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_target = pred_target_q;

`ifdef BTB_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups_q, stat_hits_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups_q <= '0;
            stat_hits_q    <= '0;
        end else begin
            if (lk_fire && !(&stat_lookups_q)) stat_lookups_q <= stat_lookups_q + 32'd1;
            if (lk_fire && entry_hit && !(&stat_hits_q)) stat_hits_q <= stat_hits_q + 32'd1;
        end
    end

    assign bus.stat_lookups = stat_lookups_q;
    assign bus.stat_hits    = stat_hits_q;
`else
    assign bus.stat_lookups = '0;
    assign bus.stat_hits    = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor against a table-based reference model.
module tb_btb_predictor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    btb_predictor_if bus ();

    btb_predictor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one record per index.
    bit          mv   [128];
    logic [22:0] mtag [128];
    logic [31:0] mtgt [128];
    int          mctr [128];
    int          exp_lookups = 0;
    int          exp_hits = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_pred(input logic [31:0] pc, output logic hit, output logic tk,
                              output logic [31:0] tgt);
        int i;
        i   = int'(pc[8:2]);
        hit = mv[i] && (mtag[i] == pc[31:9]);
        tk  = hit && (mctr[i] >= 2);
        tgt = hit ? mtgt[i] : 32'h0;
    endtask

    task automatic model_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        int i;
        i = int'(pc[8:2]);
        if (mv[i] && mtag[i] == pc[31:9]) begin
            if (taken) begin
                mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
                mtgt[i] = tgt;
            end else begin
                mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
            end
        end else if (taken) begin
            mv[i] = 1'b1; mtag[i] = pc[31:9]; mtgt[i] = tgt; mctr[i] = 2;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 128; i++) mv[i] = 1'b0;
    endtask

    task automatic note_lookup(input logic hit);
        exp_lookups++;
        if (hit) exp_hits++;
    endtask

    task automatic chk_stats(input string tag);
`ifdef BTB_PREDICTOR_STATS_EN
        chk({tag, "_lookups"}, bus.stat_lookups, 32'(exp_lookups));
        chk({tag, "_hits"}, bus.stat_hits, 32'(exp_hits));
`else
        chk({tag, "_lookups"}, bus.stat_lookups, 32'h0);
        chk({tag, "_hits"}, bus.stat_hits, 32'h0);
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response.
    task automatic lookup(input logic [31:0] pc);
        logic h, t;
        logic [31:0] g;
        model_pred(pc, h, t, g);
        bus.lk_valid = 1'b1;
        bus.lk_pc    = pc;
        #1 chk("lk_ready_idle", bus.lk_ready, 1);
        @(negedge clk);
        bus.lk_valid = 1'b0;
        chk("pred_valid", bus.pred_valid, 1);
        chk("pred_taken", bus.pred_taken, t);
        chk("pred_target", bus.pred_target, g);
        note_lookup(h);
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
        #1 chk("upd_ready_idle", bus.upd_ready, 1);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        model_upd(pc, taken, tgt);
        #1 chk("lk_ready_drain", bus.lk_ready, 0);
        chk("pred_valid_idle", bus.pred_valid, 0);
        @(negedge clk);
    endtask

    initial begin
        logic h, t, h2, t2;
        logic [31:0] g, g2, pc;

        bus.lk_valid = 0; bus.lk_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0;
        bus.upd_taken = 0; bus.upd_target = 0; bus.flush = 0;
        model_clear();

        repeat (2) @(negedge clk);
        chk("rst_pred_valid", bus.pred_valid, 0);
        chk("rst_pred_taken", bus.pred_taken, 0);
        chk("rst_pred_target", bus.pred_target, 0);
        chk_stats("rst_stat");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_lk_ready", bus.lk_ready, 1);
        chk("rst_upd_ready", bus.upd_ready, 1);

        // Cold miss, allocation, counter walk through both saturation limits.
        lookup(32'h0000_1000);
        update(32'h0000_1000, 1'b1, 32'h0000_2000);
        lookup(32'h0000_1000);
        repeat (3) begin
            update(32'h0000_1000, 1'b0, 32'h0);
            lookup(32'h0000_1000);
        end
        repeat (4) begin
            update(32'h0000_1000, 1'b1, 32'h0000_2000);
            lookup(32'h0000_1000);
        end
        update(32'h0000_1000, 1'b0, 32'h0);
        lookup(32'h0000_1000);

        // Same index, different tag.
        lookup(32'h0001_1000);
        update(32'h0001_1040, 1'b0, 32'h0000_7777);
        lookup(32'h0001_1040);

        // Update while fetch keeps lk_valid high: one stall cycle, then new data.
        model_pred(32'h0000_1000, h, t, g);
        bus.lk_valid = 1'b1; bus.lk_pc = 32'h0000_1000;
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h0000_1000;
        bus.upd_taken = 1'b1; bus.upd_target = 32'h0000_3000;
        #1 chk("stall_lk_ready_a", bus.lk_ready, 1);
        chk("stall_upd_ready_a", bus.upd_ready, 1);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        model_upd(32'h0000_1000, 1'b1, 32'h0000_3000);
        note_lookup(h);
        chk("stall_pred_valid_b", bus.pred_valid, 1);
        chk("stall_pred_taken_b", bus.pred_taken, t);
        chk("stall_pred_target_b", bus.pred_target, g);
        #1 chk("stall_lk_ready_b", bus.lk_ready, 0);
        @(negedge clk);
        chk("stall_pred_valid_c", bus.pred_valid, 0);
        #1 chk("stall_lk_ready_c", bus.lk_ready, 1);
        model_pred(32'h0000_1000, h2, t2, g2);
        @(negedge clk);
        bus.lk_valid = 1'b0;
        note_lookup(h2);
        chk("stall_pred_valid_d", bus.pred_valid, 1);
        chk("stall_pred_taken_d", bus.pred_taken, t2);
        chk("stall_pred_target_d", bus.pred_target, g2);
        @(negedge clk);

        // Back-to-back updates to one index: second RMW sees the first write.
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h0000_2040;
        bus.upd_taken = 1'b1; bus.upd_target = 32'h0000_4444;
        #1 chk("b2b_upd_ready_1", bus.upd_ready, 1);
        @(negedge clk);
        model_upd(32'h0000_2040, 1'b1, 32'h0000_4444);
        bus.upd_taken = 1'b0; bus.upd_target = 32'h0000_9999;
        #1 chk("b2b_upd_ready_2", bus.upd_ready, 1);
        @(negedge clk);
        model_upd(32'h0000_2040, 1'b0, 32'h0000_9999);
        bus.upd_valid = 1'b0;
        @(negedge clk);
        lookup(32'h0000_2040);

        // Random mix over a small aliasing PC pool.
        for (int n = 0; n < 80; n++) begin
            pc = {$urandom_range(0, 2) == 0 ? 23'h0 : 23'(1 + $urandom_range(0, 1)),
                  7'($urandom_range(0, 3) * 9), 2'b00};
            if ($urandom_range(0, 1) == 1) update(pc, 1'($urandom_range(0, 1)), $urandom);
            else lookup(pc);
        end
        chk_stats("stat_pre_flush");

        // Flush with a concurrent update: handshake accepted, payload dropped.
        bus.flush = 1'b1;
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h0000_1000;
        bus.upd_taken = 1'b1; bus.upd_target = 32'h0000_5555;
        #1 chk("flush_upd_ready", bus.upd_ready, 1);
        chk("flush_lk_ready", bus.lk_ready, 0);
        @(negedge clk);
        bus.flush = 1'b0; bus.upd_valid = 1'b0;
        model_clear();
        #1 chk("flush_no_pend", bus.lk_ready, 1);
        chk("flush_pred_valid", bus.pred_valid, 0);
        chk_stats("stat_post_flush");
        @(negedge clk);
        lookup(32'h0000_1000);
        lookup(32'h0000_2040);
        lookup(32'h0000_1024);

        // Reset in the middle of a drain: the write must not land.
        update(32'h0000_1000, 1'b1, 32'h0000_6000);
        bus.upd_valid = 1'b1; bus.upd_pc = 32'h0000_1080;
        bus.upd_taken = 1'b1; bus.upd_target = 32'h0000_6666;
        @(negedge clk);
        bus.upd_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_clear();
        exp_lookups = 0; exp_hits = 0;
        #1 chk("mid_rst_lk_ready", bus.lk_ready, 1);
        chk("mid_rst_pred_taken", bus.pred_taken, 0);
        chk("mid_rst_pred_target", bus.pred_target, 0);
        chk_stats("mid_rst_stat");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lookup(32'h0000_1080);
        lookup(32'h0000_1000);
        chk_stats("stat_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
